canonical_collect: RTL and testbench
====================================

Name: canonical_collect

Overview:
- Downstream stage of the canonical-form reduction block.
- Captures the canonicalized stabilizer rows streamed out of the Z-block tail (literals/phase/flag), together with the one-shot P vector derived from -Z rows.
- Replays the rows to the next emulation stage over a valid/ready handshake.
- Flags row-count anomalies so the stabilizer-emulation controller can detect a malformed reduction.

Parameters:
num_qubit, 4, number of qubits; also the number of rows in the stabilizer matrix and the buffer depth.
CW, $clog2(num_qubit+1), derived localparam; width of the row pointers and counters.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  asynchronous, active-high reset.
start  in  1  synchronous clear; begins a new capture; same meaning as the upstream block's start.
literals_in  in  [1:0] x num_qubit  row literals from the canonical stage output (opaque 2-bit code, 2'd0 = I).
phase_in  in  1  row phase.
flag_in  in  1  row valid; 1 = real stabilizer row, 0 = padding I row.
literals_P_in  in  [1:0] x num_qubit  P vector from the canonical stage.
valid_P_in  in  1  single-cycle pulse; literals_P_in is valid.
out_literals  out  [1:0] x num_qubit  replay row literals.
out_phase  out  1  replay row phase.
out_valid  out  1  replay row present.
out_ready  in  1  downstream accepts the row.
out_last  out  1  the current replay row is row num_qubit-1.
p_literals  out  [1:0] x num_qubit  latched P vector.
p_valid  out  1  P vector has been latched for this run.
busy  out  1  state != IDLE.
overflow  out  1  sticky; a flagged row arrived after the buffer was full.
row_count  out  CW  number of rows captured.

Behaviour:
- States: IDLE, CAPTURE, WAIT_P, DRAIN. Two-bit state register.
- Reset (rst high, asynchronous):
  - state=IDLE.
  - Buffer rows, phases, p_literals cleared to 0.
  - wr_ptr=rd_ptr=0.
  - p_valid=0, overflow=0, row_count=0.
  - All outputs 0.
- start (synchronous, priority over everything else):
  - Same clears as reset, then state=CAPTURE.
  - A flag_in or valid_P_in present on the start cycle is ignored.
- IDLE:
  - flag_in and valid_P_in are ignored.
  - Outputs hold; p_literals/p_valid persist until the next start.
- CAPTURE:
  - Each cycle with flag_in=1: buf[wr_ptr] <= {literals_in, phase_in}; wr_ptr++ and row_count++.
  - flag_in=0 cycles are skipped (no write).
  - Writing row num_qubit-1 sets full. Next state: WAIT_P if p_valid is still 0, else DRAIN.
- P latch:
  - valid_P_in=1 in CAPTURE or WAIT_P: p_literals <= literals_P_in and p_valid <= 1.
  - A second pulse before the next start overwrites p_literals.
  - A P pulse on the same cycle as the final row write counts as latched; go directly to DRAIN.
- WAIT_P:
  - valid_P_in -> DRAIN on the next cycle.
  - flag_in=1 -> overflow <= 1; the row is discarded and row_count saturates at num_qubit.
- DRAIN:
  - out_valid=1; out_literals/out_phase = buf[rd_ptr], driven combinationally from the registered buffer.
  - out_last = (rd_ptr == num_qubit-1).
  - On out_valid & out_ready: rd_ptr++.
  - On the handshake with out_last=1: rd_ptr=0, state=IDLE, out_valid=0 on the next cycle.
  - Data is held stable while out_ready=0.
  - flag_in=1 in DRAIN also sets overflow.
- out_valid is 0 in every state except DRAIN. Latency from the P pulse (rows already full) to the first out_valid is 1 cycle.
- busy = (state != IDLE).
- Mid-operation start in any state aborts the run immediately; no partial replay. A rst assertion behaves identically, asynchronously.

Decomposition:
- Package canonical_pkg:
  - literal_t (logic [1:0]) and the LIT_I constant.
  - row_t struct {literal_t lit[num_qubit]; logic phase} as a parameterized typedef, or via a macro if the toolchain lacks parameterized types.
  - collect_state_t enum (IDLE/CAPTURE/WAIT_P/DRAIN).
- One sub-module: canonical_row_buffer.
  - num_qubit x row register file.
  - One write port (we, waddr, wdata), one combinational read port (raddr, rdata), synchronous clear.
  - FSM and counters stay in canonical_collect.

Test Plan:
1. num_qubit=4, start, then 4 consecutive flag_in=1 rows (row k literals all 2'd(k%4), phase=k[0]), valid_P_in with P={0,2,0,2} one cycle later, out_ready=1 -> out_valid high for exactly 4 cycles; rows 0..3 in order; out_last only on row 3; p_literals={0,2,0,2}; p_valid=1; overflow=0; row_count=4.
2. Rows interleaved with flag_in=0 padding (pattern 1,0,1,1,0,1) -> only the 4 flagged rows stored in arrival order; padding never appears on out_literals.
3. DRAIN with out_ready toggling 1,0,0,1,1,0,1 -> each row is held stable while ready=0; exactly 4 handshakes; return to IDLE one cycle after the 4th.
4. Fifth flag_in=1 row in WAIT_P -> overflow=1 and sticky through DRAIN; row_count stays 4; the replay contains only the first 4 rows; the next start clears overflow.
5. valid_P_in arrives before the buffer is full (after row 1) -> p_valid=1 immediately; DRAIN starts the cycle after row 3 is written with no WAIT_P dwell.
6. start asserted mid-DRAIN after 2 handshakes -> out_valid=0 next cycle; p_valid=0; row_count=0; state CAPTURE. Async rst mid-CAPTURE clears all outputs without a clock edge.

Source files
------------

// File: rtl/canonical_pkg.sv
// ============================================================================
// Module   : canonical_pkg
// Brief    : Shared types and constants for the canonical-form collect stage.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package canonical_pkg;

  typedef logic [1:0] literal_t;

  localparam literal_t LIT_I = 2'd0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    WAIT_P  = 2'd2,
    DRAIN   = 2'd3
  } collect_state_t;

  // Address width for a register file of the given depth, never below 1 bit.
  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/canonical_row_buffer.sv
// ============================================================================
// Module   : canonical_row_buffer
// Brief    : DEPTH x ROW_W register file, one write port, one async read port.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module canonical_row_buffer #(
  parameter int DEPTH = 4,
  parameter int ROW_W = 9,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [ROW_W-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [ROW_W-1:0] o_rdata
);

  logic [ROW_W-1:0] r_mem [DEPTH];

  for (genvar g = 0; g < DEPTH; g++) begin : g_row
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_mem[g] <= '0;
      end else if (i_clr) begin
        r_mem[g] <= '0;
      end else if (i_we && (i_waddr == AW'(g))) begin
        r_mem[g] <= i_wdata;
      end
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

`default_nettype wire

// File: rtl/canonical_collect.sv
// ============================================================================
// Module   : canonical_collect
// Brief    : Captures canonicalized stabilizer rows and the P vector, then
//            replays the rows downstream over a valid/ready handshake.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module canonical_collect
  import canonical_pkg::*;
#(
  parameter int num_qubit = 4,
  localparam int CW = $clog2(num_qubit + 1)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  literal_t [num_qubit-1:0]       literals_in,
  input  logic                           phase_in,
  input  logic                           flag_in,
  input  literal_t [num_qubit-1:0]       literals_P_in,
  input  logic                           valid_P_in,
  output literal_t [num_qubit-1:0]       out_literals,
  output logic                           out_phase,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           out_last,
  output literal_t [num_qubit-1:0]       p_literals,
  output logic                           p_valid,
  output logic                           busy,
  output logic                           overflow,
  output logic [CW-1:0]                  row_count
);

  localparam int            AW     = addr_width(num_qubit);
  localparam logic [CW-1:0] C_LAST = CW'(num_qubit - 1);

  typedef struct packed {
    literal_t [num_qubit-1:0] lit;
    logic                     phase;
  } row_t;

  collect_state_t           r_state;
  collect_state_t           w_state_nxt;
  logic [CW-1:0]            r_wr_ptr;
  logic [CW-1:0]            r_rd_ptr;
  logic                     r_p_valid;
  logic                     r_overflow;
  literal_t [num_qubit-1:0] r_p_literals;

  row_t w_wr_row;
  row_t w_rd_row;
  logic w_we;
  logic w_last_write;
  logic w_handshake;
  logic w_out_last;
  logic w_out_valid;
  logic w_busy;

  // The write pointer doubles as the row counter; it only advances in CAPTURE,
  // so it naturally saturates at num_qubit.
  assign w_we         = (r_state == CAPTURE) && flag_in && !start;
  assign w_last_write = w_we && (r_wr_ptr == C_LAST);
  assign w_out_last   = (r_rd_ptr == C_LAST);
  assign w_handshake  = (r_state == DRAIN) && out_ready;

  assign w_wr_row.lit   = literals_in;
  assign w_wr_row.phase = phase_in;

  canonical_row_buffer #(
    .DEPTH (num_qubit),
    .ROW_W ($bits(row_t)),
    .AW    (AW)
  ) u_row_buffer (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (start),
    .i_we    (w_we),
    .i_waddr (r_wr_ptr[AW-1:0]),
    .i_wdata (w_wr_row),
    .i_raddr (r_rd_ptr[AW-1:0]),
    .o_rdata (w_rd_row)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_out_valid = (r_state == DRAIN);
    w_busy      = (r_state != IDLE);
    if (start) begin
      w_state_nxt = CAPTURE;
    end else begin
      case (r_state)
        IDLE:    w_state_nxt = IDLE;
        CAPTURE: if (w_last_write) w_state_nxt = (r_p_valid || valid_P_in) ? DRAIN : WAIT_P;
        WAIT_P:  if (valid_P_in) w_state_nxt = DRAIN;
        DRAIN:   if (w_handshake && w_out_last) w_state_nxt = IDLE;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_p_valid    <= 1'b0;
      r_overflow   <= 1'b0;
      r_p_literals <= {num_qubit{LIT_I}};
    end else begin
      r_state <= w_state_nxt;
      if (start) begin
        r_wr_ptr     <= '0;
        r_rd_ptr     <= '0;
        r_p_valid    <= 1'b0;
        r_overflow   <= 1'b0;
        r_p_literals <= {num_qubit{LIT_I}};
      end else begin
        if (w_we) begin
          r_wr_ptr <= r_wr_ptr + CW'(1);
        end
        if (valid_P_in && ((r_state == CAPTURE) || (r_state == WAIT_P))) begin
          r_p_literals <= literals_P_in;
          r_p_valid    <= 1'b1;
        end
        if (flag_in && ((r_state == WAIT_P) || (r_state == DRAIN))) begin
          r_overflow <= 1'b1;
        end
        if (w_handshake) begin
          r_rd_ptr <= w_out_last ? '0 : r_rd_ptr + CW'(1);
        end
      end
    end
  end

  assign out_literals = w_rd_row.lit;
  assign out_phase    = w_rd_row.phase;
  assign out_valid    = w_out_valid;
  assign out_last     = w_out_valid && w_out_last;
  assign p_literals   = r_p_literals;
  assign p_valid      = r_p_valid;
  assign busy         = w_busy;
  assign overflow     = r_overflow;
  assign row_count    = r_wr_ptr;

endmodule

`default_nettype wire

// File: tb/tb_canonical_collect.sv
// ============================================================================
// Module   : tb_canonical_collect
// Brief    : Scoreboard bench for canonical_collect (num_qubit = 4).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_canonical_collect;

  localparam int NQ = 4;
  localparam int CW = $clog2(NQ + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [NQ-1:0][1:0] literals_in;
  logic          phase_in;
  logic          flag_in;
  logic [NQ-1:0][1:0] literals_P_in;
  logic          valid_P_in;
  logic [NQ-1:0][1:0] out_literals;
  logic          out_phase;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic [NQ-1:0][1:0] p_literals;
  logic          p_valid;
  logic          busy;
  logic          overflow;
  logic [CW-1:0] row_count;

  typedef struct {
    logic [2*NQ-1:0] lit;
    logic            ph;
  } exp_t;

  exp_t sb[$];
  int   m_count;
  int   vectors = 0;
  int   errors  = 0;

  always #5 clk = ~clk;

  canonical_collect #(.num_qubit(NQ)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .literals_in   (literals_in),
    .phase_in      (phase_in),
    .flag_in       (flag_in),
    .literals_P_in (literals_P_in),
    .valid_P_in    (valid_P_in),
    .out_literals  (out_literals),
    .out_phase     (out_phase),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_last      (out_last),
    .p_literals    (p_literals),
    .p_valid       (p_valid),
    .busy          (busy),
    .overflow      (overflow),
    .row_count     (row_count)
  );

  function automatic logic [2*NQ-1:0] rowlit(input int k);
    logic [1:0] v;
    v = k[1:0];
    return {v, v, v, v};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    flag_in = 1'b1;
    valid_P_in = 1'b1;
    tick();
    start = 1'b0;
    flag_in = 1'b0;
    valid_P_in = 1'b0;
    sb.delete();
    m_count = 0;
  endtask

  // Drive one cycle of inputs; flagged rows below capacity are expected back.
  task automatic send(input logic fl, input logic [2*NQ-1:0] lit, input logic ph,
                      input logic vp, input logic [2*NQ-1:0] p);
    flag_in       = fl;
    literals_in   = lit;
    phase_in      = ph;
    valid_P_in    = vp;
    literals_P_in = p;
    if (fl && (m_count < NQ)) begin
      sb.push_back('{lit: lit, ph: ph});
      m_count++;
    end
    tick();
    flag_in    = 1'b0;
    valid_P_in = 1'b0;
  endtask

  // Replay monitor: compares each presented row against the scoreboard head.
  task automatic drain(input logic [15:0] pat, input int plen, input int stop_after,
                       output int hs, output int vcyc);
    int   cyc;
    logic rdy;
    exp_t e;
    cyc  = 0;
    hs   = 0;
    vcyc = 0;
    while ((hs < stop_after) && (cyc < 40)) begin
      rdy = (cyc < plen) ? pat[cyc] : 1'b1;
      out_ready = rdy;
      if (out_valid) begin
        vcyc++;
        vectors++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL drain_row got %h/%b want no row (scoreboard empty)", out_literals, out_phase);
        end else begin
          e = sb[0];
          if ((out_literals !== e.lit) || (out_phase !== e.ph)) begin
            errors++;
            $display("FAIL drain_row%0d got %h/%b want %h/%b", hs, out_literals, out_phase, e.lit, e.ph);
          end
        end
        vectors++;
        if (out_last !== (hs == NQ - 1)) begin
          errors++;
          $display("FAIL drain_last%0d got %b want %b", hs, out_last, (hs == NQ - 1));
        end
        if (rdy) begin
          if (sb.size() != 0) void'(sb.pop_front());
          hs++;
        end
      end
      tick();
      cyc++;
    end
    out_ready = 1'b0;
    vectors++;
    if (hs < stop_after) begin
      errors++;
      $display("FAIL drain_timeout got %0d handshakes want %0d", hs, stop_after);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    flag_in = 1'b0;
    valid_P_in = 1'b0;
    out_ready = 1'b0;
    phase_in = 1'b0;
    literals_in = '0;
    literals_P_in = '0;
    #3;
    vectors++;
    if ({out_valid, out_last, busy, p_valid, overflow, out_phase} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags got %b want 000000", {out_valid, out_last, busy, p_valid, overflow, out_phase});
    end
    vectors++;
    if ((row_count !== '0) || (out_literals !== '0) || (p_literals !== '0)) begin
      errors++;
      $display("FAIL reset_data got cnt=%0d out=%h p=%h want 0/0/0", row_count, out_literals, p_literals);
    end
    tick();
    rst = 1'b0;
    tick();
    vectors++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle_busy got %b want 0", busy);
    end
  endtask

  task automatic test_basic();
    int hs, vcyc;
    do_start();
    vectors++;
    if ((busy !== 1'b1) || (row_count !== '0) || (p_valid !== 1'b0)) begin
      errors++;
      $display("FAIL basic_start got busy=%b cnt=%0d pv=%b want 1/0/0", busy, row_count, p_valid);
    end
    for (int k = 0; k < NQ; k++) send(1'b1, rowlit(k), k[0], 1'b0, '0);
    vectors++;
    if ((out_valid !== 1'b0) || (busy !== 1'b1) || (row_count !== CW'(4))) begin
      errors++;
      $display("FAIL basic_waitp got ov=%b busy=%b cnt=%0d want 0/1/4", out_valid, busy, row_count);
    end
    send(1'b0, '0, 1'b0, 1'b1, 8'b00_10_00_10);
    vectors++;
    if ((out_valid !== 1'b1) || (p_valid !== 1'b1) || (p_literals !== 8'b00_10_00_10)) begin
      errors++;
      $display("FAIL basic_p got ov=%b pv=%b p=%h want 1/1/22", out_valid, p_valid, p_literals);
    end
    drain(16'hFFFF, 0, NQ, hs, vcyc);
    vectors++;
    if ((vcyc !== 4) || (out_valid !== 1'b0) || (busy !== 1'b0)) begin
      errors++;
      $display("FAIL basic_end got vcyc=%0d ov=%b busy=%b want 4/0/0", vcyc, out_valid, busy);
    end
    vectors++;
    if ((overflow !== 1'b0) || (row_count !== CW'(4)) || (p_valid !== 1'b1)) begin
      errors++;
      $display("FAIL basic_status got of=%b cnt=%0d pv=%b want 0/4/1", overflow, row_count, p_valid);
    end
  endtask

  task automatic test_padding();
    logic [5:0] pat;
    int hs, vcyc;
    pat = 6'b101101;
    do_start();
    for (int i = 0; i < 6; i++) begin
      send(pat[i], 8'($urandom) | 8'h01, 1'($urandom), 1'b0, '0);
    end
    vectors++;
    if (row_count !== CW'(4)) begin
      errors++;
      $display("FAIL pad_count got %0d want 4", row_count);
    end
    send(1'b0, '0, 1'b0, 1'b1, 8'h5A);
    drain(16'hFFFF, 0, NQ, hs, vcyc);
  endtask

  task automatic test_backpressure();
    int hs, vcyc;
    do_start();
    for (int k = 0; k < NQ - 1; k++) send(1'b1, 8'($urandom), 1'($urandom), 1'b0, '0);
    send(1'b1, 8'($urandom), 1'b1, 1'b1, 8'hC3);
    vectors++;
    if ((out_valid !== 1'b1) || (p_valid !== 1'b1) || (p_literals !== 8'hC3)) begin
      errors++;
      $display("FAIL bp_direct got ov=%b pv=%b p=%h want 1/1/c3", out_valid, p_valid, p_literals);
    end
    drain(16'b1011001, 7, NQ, hs, vcyc);
    vectors++;
    if ((vcyc !== 7) || (out_valid !== 1'b0) || (busy !== 1'b0)) begin
      errors++;
      $display("FAIL bp_end got vcyc=%0d ov=%b busy=%b want 7/0/0", vcyc, out_valid, busy);
    end
  endtask

  task automatic test_overflow();
    int hs, vcyc;
    do_start();
    for (int k = 4; k < 8; k++) send(1'b1, rowlit(k + 1), k[0], 1'b0, '0);
    send(1'b1, 8'hFF, 1'b1, 1'b0, '0);
    vectors++;
    if ((overflow !== 1'b1) || (row_count !== CW'(4)) || (out_valid !== 1'b0)) begin
      errors++;
      $display("FAIL ovf_set got of=%b cnt=%0d ov=%b want 1/4/0", overflow, row_count, out_valid);
    end
    send(1'b0, '0, 1'b0, 1'b1, 8'h11);
    drain(16'hFFFF, 0, NQ, hs, vcyc);
    vectors++;
    if ((overflow !== 1'b1) || (row_count !== CW'(4))) begin
      errors++;
      $display("FAIL ovf_sticky got of=%b cnt=%0d want 1/4", overflow, row_count);
    end
    do_start();
    vectors++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clear got %b want 0", overflow);
    end
  endtask

  task automatic test_early_p();
    int hs, vcyc;
    do_start();
    send(1'b1, rowlit(1), 1'b1, 1'b0, '0);
    send(1'b1, rowlit(2), 1'b0, 1'b0, '0);
    send(1'b0, '0, 1'b0, 1'b1, 8'h99);
    vectors++;
    if ((p_valid !== 1'b1) || (p_literals !== 8'h99) || (out_valid !== 1'b0)) begin
      errors++;
      $display("FAIL early_p got pv=%b p=%h ov=%b want 1/99/0", p_valid, p_literals, out_valid);
    end
    send(1'b0, '0, 1'b0, 1'b1, 8'h66);
    send(1'b1, rowlit(3), 1'b1, 1'b0, '0);
    vectors++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL early_mid got ov=%b want 0", out_valid);
    end
    send(1'b1, 8'hE4, 1'b0, 1'b0, '0);
    vectors++;
    if ((out_valid !== 1'b1) || (p_literals !== 8'h66)) begin
      errors++;
      $display("FAIL early_drain got ov=%b p=%h want 1/66", out_valid, p_literals);
    end
    drain(16'hFFFF, 0, NQ, hs, vcyc);
  endtask

  task automatic test_abort();
    int hs, vcyc;
    do_start();
    for (int k = 0; k < NQ; k++) send(1'b1, rowlit(k + 1), 1'b1, 1'b0, '0);
    send(1'b0, '0, 1'b0, 1'b1, 8'h3C);
    drain(16'hFFFF, 0, 2, hs, vcyc);
    do_start();
    vectors++;
    if ((out_valid !== 1'b0) || (p_valid !== 1'b0) || (row_count !== '0) || (busy !== 1'b1)) begin
      errors++;
      $display("FAIL abort_start got ov=%b pv=%b cnt=%0d busy=%b want 0/0/0/1",
               out_valid, p_valid, row_count, busy);
    end
    send(1'b1, rowlit(1), 1'b1, 1'b1, 8'hAA);
    send(1'b1, rowlit(2), 1'b0, 1'b0, '0);
    vectors++;
    if ((row_count !== CW'(2)) || (p_valid !== 1'b1)) begin
      errors++;
      $display("FAIL abort_pre got cnt=%0d pv=%b want 2/1", row_count, p_valid);
    end
    #2;
    rst = 1'b1;
    #1;
    vectors++;
    if ((row_count !== '0) || (p_valid !== 1'b0) || (busy !== 1'b0) || (out_literals !== '0) ||
        (p_literals !== '0) || (out_phase !== 1'b0) || (out_valid !== 1'b0)) begin
      errors++;
      $display("FAIL abort_rst got cnt=%0d pv=%b busy=%b out=%h p=%h ph=%b ov=%b want all 0",
               row_count, p_valid, busy, out_literals, p_literals, out_phase, out_valid);
    end
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    m_count = 0;
    test_reset();
    test_basic();
    test_padding();
    test_backpressure();
    test_overflow();
    test_early_p();
    test_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got no completion want finish before 200000");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
